// File: rtl/spi_frame_slave.sv
// spi_frame_slave: oversampled SPI slave with multi-word frames.
// Received frames are double-buffered and only applied to q on a rising
// edge of the update strobe (vsync), so downstream logic never sees a torn
// frame. A transmit frame is shifted back out on sdi.
// Optional feature macro: SPI_TIMEOUT_EN drops a stalled partial frame
// after TIMEOUT idle clk cycles and pulses timeout.
module spi_frame_slave #(
   parameter int WIDTH       = 32,
   parameter int WORDS       = 1,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sck,
   input  logic                     sdo,
   output logic                     sdi,
   input  logic [WIDTH*WORDS-1:0]   d,
   input  logic                     update,
   output logic [WIDTH*WORDS-1:0]   q,
   output logic                     frame_done,
   output logic                     overrun,
   output logic                     timeout
);

   localparam int FW = WIDTH * WORDS;
   localparam int CW = (FW > 1) ? $clog2(FW) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(FW - 1);

   logic [SYNC_STAGES-1:0] sckSync_q;
   logic [SYNC_STAGES-1:0] sdoSync_q;
   logic [SYNC_STAGES-1:0] updSync_q;
   logic                   sckLast_q;
   logic                   updLast_q;

   logic [CW-1:0]          bitCnt_q;
   logic [FW-1:0]          qSR_q;
   logic [FW-1:0]          dSR_q;
   logic                   sdi_q;
   logic [FW-1:0]          qbuf_q;
   logic                   pending_q;
   logic [FW-1:0]          qOut_q;
   logic                   frameDone_q;
   logic                   overrun_q;

   logic                   sckS;
   logic                   sdoS;
   logic                   updS;
   logic                   sckFall;
   logic                   updRise;
   logic                   frameEnd;
   logic                   dropFrame;
   logic [FW-1:0]          newFrame_d;

   assign sckS     = sckSync_q[SYNC_STAGES-1];
   assign sdoS     = sdoSync_q[SYNC_STAGES-1];
   assign updS     = updSync_q[SYNC_STAGES-1];
   assign sckFall  = sckLast_q & ~sckS;
   assign updRise  = updS & ~updLast_q;
   assign frameEnd = sckFall && (bitCnt_q == LAST_BIT);
   assign newFrame_d = (qSR_q << 1) | {{(FW-1){1'b0}}, sdoS};

   // Bring the asynchronous pins into the clk domain and keep one extra flop for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sckSync_q <= '0;
         sdoSync_q <= '0;
         updSync_q <= '0;
         sckLast_q <= 1'b0;
         updLast_q <= 1'b0;
      end else begin
         sckSync_q <= {sckSync_q[SYNC_STAGES-2:0], sck};
         sdoSync_q <= {sdoSync_q[SYNC_STAGES-2:0], sdo};
         updSync_q <= {updSync_q[SYNC_STAGES-2:0], update};
         sckLast_q <= sckS;
         updLast_q <= updS;
      end
   end

`ifdef SPI_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT + 1);
   logic [IW-1:0] idleCnt_q;
   logic          timeout_q;

   assign dropFrame = (bitCnt_q != '0) && !sckFall && (idleCnt_q == IW'(TIMEOUT));
   assign timeout   = timeout_q;

   // Count idle cycles inside a partial frame, saturating at TIMEOUT, and pulse when the frame is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idleCnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= dropFrame;
         if (sckFall) begin
            idleCnt_q <= '0;
         end else if ((bitCnt_q != '0) && (idleCnt_q != IW'(TIMEOUT))) begin
            idleCnt_q <= idleCnt_q + IW'(1);
         end
      end
   end
`else
   assign dropFrame = 1'b0;
   assign timeout   = 1'b0;
`endif

   // Shift receive and transmit registers on each synced sck falling edge; reload transmit data while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bitCnt_q <= '0;
         qSR_q    <= '0;
         dSR_q    <= '0;
         sdi_q    <= 1'b0;
      end else if (dropFrame) begin
         bitCnt_q <= '0;
         qSR_q    <= '0;
         dSR_q    <= d;
         sdi_q    <= d[FW-1];
      end else if (sckFall) begin
         sdi_q    <= dSR_q[FW-2];
         dSR_q    <= dSR_q << 1;
         qSR_q    <= newFrame_d;
         bitCnt_q <= frameEnd ? '0 : bitCnt_q + CW'(1);
      end else if (bitCnt_q == '0) begin
         dSR_q    <= d;
         sdi_q    <= d[FW-1];
      end
   end

   // Park completed frames in qbuf and hand them to q on an update edge; a frame landing with the edge goes straight through.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         qbuf_q      <= '0;
         pending_q   <= 1'b0;
         qOut_q      <= '0;
         frameDone_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frameDone_q <= frameEnd;
         overrun_q   <= frameEnd && pending_q && !updRise;
         if (frameEnd) begin
            qbuf_q <= newFrame_d;
            if (updRise) begin
               qOut_q    <= newFrame_d;
               pending_q <= 1'b0;
            end else begin
               pending_q <= 1'b1;
            end
         end else if (updRise && pending_q) begin
            qOut_q    <= qbuf_q;
            pending_q <= 1'b0;
         end
      end
   end

   assign sdi        = sdi_q;
   assign q          = qOut_q;
   assign frame_done = frameDone_q;
   assign overrun    = overrun_q;

endmodule

// File: doc/spi_frame_slave.md
Name: spi_frame_slave

Overview:
- Parametrised successor to the per-player SPI slave that links each PIC to the FPGA.
- Oversamples the SPI pins in the system clock domain and supports multi-word frames.
- Double-buffers received frames and presents them to the game logic only on an update strobe (the VGA vsync), so video never sees a torn frame.
- Also shifts a transmit word back to the PIC and reports frame-done and overrun status.

Parameters:
- WIDTH, 32, bits per word
- WORDS, 1, words per frame; frame width FW = WIDTH*WORDS
- SYNC_STAGES, 2, synchroniser depth for sck, sdo and update (minimum 2)
- TIMEOUT, 1024, idle clk cycles before a partial frame is dropped (used only with SPI_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- sck  in  1  SPI clock from PIC, asynchronous to clk
- sdo  in  1  SPI data from PIC
- sdi  out  1  SPI data to PIC, registered
- d  in  FW  transmit frame
- update  in  1  apply strobe (vsync), asynchronous, rising-edge active
- q  out  FW  applied received frame
- frame_done  out  1  one-cycle pulse when a full frame has been received
- overrun  out  1  one-cycle pulse when an unapplied frame is overwritten
- timeout  out  1  one-cycle pulse when a partial frame is dropped; tied to 0 without SPI_TIMEOUT_EN

Behaviour:
- Reset state: q=0, sdi=0, frame_done=0, overrun=0, timeout=0; bit counter, shift registers, qbuf and pending all 0.
- Synchronisation:
  - sck, sdo and update each pass through SYNC_STAGES flops.
  - An edge detect compares the last sync stage with one extra flop.
  - Pin-to-event latency is SYNC_STAGES+1 clk cycles.
  - Required: sck high time and low time each >= SYNC_STAGES+2 clk periods. Behaviour is undefined if this is violated.
- Sampling edge: the falling edge of synced sck is the only active SPI edge (same polarity as the existing link).
- Transmit:
  - While the bit counter is 0 and no falling edge occurs this cycle, dSR <= d every clk, and sdi shows d[FW-1].
  - On each falling edge: sdi <= dSR[FW-2] and dSR shifts left with zero fill.
  - After k edges, sdi = d[FW-1-k] where d is the value captured before edge 1.
  - d changes mid-frame are ignored.
- Receive:
  - On each falling edge: qSR <= {qSR[FW-2:0], sdo_s}. Data is MSB first.
  - The bit counter increments, with width clog2(FW).
  - On the edge that completes bit FW-1:
    - qbuf <= {qSR[FW-2:0], sdo_s}
    - bit counter <= 0
    - pending <= 1
    - frame_done = 1 on the next cycle, for exactly 1 cycle
    - if pending was already 1 and is not cleared in the same cycle, overrun = 1 for 1 cycle
- Apply:
  - On a synced update rising edge with pending=1: q <= qbuf, pending <= 0.
  - On a synced update rising edge with pending=0: q holds.
- Simultaneous frame completion and update edge in the same cycle:
  - The new frame goes straight to q, pending <= 0, no overrun.
  - qbuf also takes the new frame.
- Word order: word 0 is q[FW-1 -: WIDTH], the first word shifted in.
- Reset mid-frame: all state returns to reset values immediately. The next falling edge after release counts as bit 0.
- No chip select: framing relies purely on counting. A lost edge misaligns all following frames until reset, unless the timeout feature is enabled.

Optional Feature:
- Macro: SPI_TIMEOUT_EN.
- Defined:
  - An idle counter clears on every falling edge and increments while the bit counter is nonzero.
  - When it reaches TIMEOUT: bit counter <= 0, qSR <= 0, dSR reloads d, timeout pulses for 1 cycle.
  - qbuf, pending and q are untouched.
  - The idle counter saturates and does not run while the bit counter is 0.
- Undefined: no idle counter exists; a partial frame waits indefinitely; timeout is constant 0.

Test Plan:
- Reset, then idle with d=32'hA5A5_0001 → sdi=1 (MSB) within 1 clk of release; q=0, all pulses 0.
- Shift 32'hDEAD_BEEF MSB first, sck period 16 clk → frame_done pulses once, ~3 clk after the 32nd falling edge; q stays 0; on update rising edge q=32'hDEAD_BEEF SYNC_STAGES+1 clk later; the PIC reads back 32'hA5A5_0001 on sdi.
- Two frames 32'h1111_1111 then 32'h2222_2222 with no update between → overrun pulses once at the second frame_done; after update, q=32'h2222_2222.
- WORDS=2: shift 64'h0123_4567_89AB_CDEF → only one frame_done, after 64 edges; q[63:32]=32'h0123_4567 after update.
- Align the 32nd edge detect and the update edge detect to the same clk → q=new frame, overrun=0; a later update with no new frame leaves q unchanged.
- SPI_TIMEOUT_EN, TIMEOUT=64: send 10 bits then stop for 100 clk → timeout pulses once at idle count 64; a following full frame of 32'hCAFE_F00D is received correctly. With the macro undefined, the same stimulus gives a misaligned result and timeout stays 0.
